// File: rtl/pingpong_bank_writer.sv
// Write side of a two-bank ping-pong buffer: fills ram1/ram2 alternately from a
// valid/ready byte stream and offers each completed bank to the reader until released.
module pingpong_bank_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram1_write_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic              ram2_write_en,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic              full_valid,
  output logic              full_bank,
  input  logic              full_release
);

  typedef enum logic {ST_FILL, ST_WAIT} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic              wr_bank_reg, wr_bank_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [1:0]        bank_full_reg, bank_full_next;
  logic              full_valid_reg;
  logic              full_bank_reg, full_bank_next;
  logic              accept;
  logic              release_ok;

  logic              bank_we   [2];
  logic [ADDR_W-1:0] bank_addr [2];
  logic [DATA_W-1:0] bank_data [2];

  assign in_ready   = (state_reg == ST_FILL);
  assign accept     = in_valid & in_ready;
  assign release_ok = full_release & full_valid_reg;

  always_comb begin
    state_next     = state_reg;
    wr_bank_next   = wr_bank_reg;
    wr_ptr_next    = wr_ptr_reg;
    bank_full_next = bank_full_reg;
    full_bank_next = full_bank_reg;

    // Release is applied first so a bank freed this cycle is already usable
    // by a bank switch happening in the same cycle.
    if (release_ok) begin
      bank_full_next[full_bank_reg] = 1'b0;
    end

    case (state_reg)
      ST_FILL: begin
        if (accept) begin
          if (wr_ptr_reg == LAST_PTR) begin
            bank_full_next[wr_bank_reg] = 1'b1;
            wr_bank_next = ~wr_bank_reg;
            wr_ptr_next  = '0;
            if (bank_full_next[~wr_bank_reg]) begin
              state_next = ST_WAIT;
            end
          end else begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!bank_full_next[wr_bank_reg]) begin
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase

    // With both banks full the already-offered (older) bank keeps its place.
    case (bank_full_next)
      2'b01:   full_bank_next = 1'b0;
      2'b10:   full_bank_next = 1'b1;
      default: full_bank_next = full_bank_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_FILL;
      wr_bank_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      bank_full_reg  <= 2'b00;
      full_valid_reg <= 1'b0;
      full_bank_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_bank_reg    <= wr_bank_next;
      wr_ptr_reg     <= wr_ptr_next;
      bank_full_reg  <= bank_full_next;
      full_valid_reg <= |bank_full_next;
      full_bank_reg  <= full_bank_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK = (gi == 1);
      logic              we_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          we_reg   <= 1'b0;
          addr_reg <= '0;
          data_reg <= '0;
        end else begin
          we_reg <= accept && (wr_bank_reg == BANK);
          if (accept && (wr_bank_reg == BANK)) begin
            addr_reg <= wr_ptr_reg;
            data_reg <= in_data;
          end
        end
      end

      assign bank_we[gi]   = we_reg;
      assign bank_addr[gi] = addr_reg;
      assign bank_data[gi] = data_reg;
    end
  endgenerate

  assign ram1_write_en      = bank_we[0];
  assign ram1_write_address = bank_addr[0];
  assign ram1_write_data    = bank_data[0];
  assign ram2_write_en      = bank_we[1];
  assign ram2_write_address = bank_addr[1];
  assign ram2_write_data    = bank_data[1];
  assign full_valid         = full_valid_reg;
  assign full_bank          = full_bank_reg;

endmodule

// File: tb/tb_pingpong_bank_writer.sv
// Bench for pingpong_bank_writer: queue-based model of bank completion order,
// per-cycle comparison of all outputs, plus literal checks on directed scenarios.
module tb_pingpong_bank_writer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              ram1_write_en, ram2_write_en;
  logic [ADDR_W-1:0] ram1_write_address, ram2_write_address;
  logic [DATA_W-1:0] ram1_write_data, ram2_write_data;
  logic              full_valid, full_bank;
  logic              full_release = 1'b0;

  pingpong_bank_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram1_write_en(ram1_write_en), .ram1_write_address(ram1_write_address),
    .ram1_write_data(ram1_write_data),
    .ram2_write_en(ram2_write_en), .ram2_write_address(ram2_write_address),
    .ram2_write_data(ram2_write_data),
    .full_valid(full_valid), .full_bank(full_bank), .full_release(full_release)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: completed banks sit in a FIFO in completion order; the writer may
  // proceed whenever its current bank is not in that FIFO.
  int q[$];
  int m_bank, m_ptr;
  bit m_acc;
  bit e_ready, e_fv, e_fb;
  bit e_we[2];
  int e_addr[2], e_data[2];

  task automatic model_reset();
    q.delete();
    m_bank = 0; m_ptr = 0; m_acc = 0;
    e_ready = 1; e_fv = 0; e_fb = 0;
    for (int b = 0; b < 2; b++) begin
      e_we[b] = 0; e_addr[b] = 0; e_data[b] = 0;
    end
  endtask

  task automatic model_step();
    bit rel;
    m_acc = in_valid && e_ready;
    rel   = full_release && (q.size() > 0);
    e_we[0] = 0; e_we[1] = 0;
    if (rel) void'(q.pop_front());
    if (m_acc) begin
      e_we[m_bank]   = 1;
      e_addr[m_bank] = m_ptr;
      e_data[m_bank] = int'(in_data);
      $display("word bank=%0d addr=%0d data=%02h", m_bank, m_ptr, in_data);
      m_ptr++;
      if (m_ptr == DEPTH) begin
        q.push_back(m_bank);
        m_bank ^= 1;
        m_ptr = 0;
      end
    end
    e_ready = 1;
    foreach (q[i]) if (q[i] == m_bank) e_ready = 0;
    e_fv = (q.size() > 0);
    if (e_fv) e_fb = q[0][0];
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
  endtask

  always @(negedge clk) begin
    check("in_ready", in_ready, e_ready);
    check("full_valid", full_valid, e_fv);
    check("full_bank", full_bank, e_fb);
    check("ram1_we", ram1_write_en, e_we[0]);
    check("ram2_we", ram2_write_en, e_we[1]);
    if (e_we[0]) begin
      check("ram1_addr", ram1_write_address, e_addr[0]);
      check("ram1_data", ram1_write_data, e_data[0]);
    end
    if (e_we[1]) begin
      check("ram2_addr", ram2_write_address, e_addr[1]);
      check("ram2_data", ram2_write_data, e_data[1]);
    end
  end

  task automatic send_word(input logic [DATA_W-1:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      done = m_acc;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_release();
    full_release = 1'b1;
    tick();
    full_release = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    check("rst_ready", in_ready, 32'd1);
    check("rst_fv", full_valid, 32'd0);
    check("rst_we1", ram1_write_en, 32'd0);

    // Scenario 1/2: two banks back to back without release
    for (int i = 0; i < 32; i++) send_word(8'(i));
    check("s1_we1", ram1_write_en, 32'd1);
    check("s1_addr31", ram1_write_address, 32'd31);
    check("s1_fv", full_valid, 32'd1);
    check("s1_fb", full_bank, 32'd0);
    check("s1_ready", in_ready, 32'd1);
    for (int i = 32; i < 64; i++) send_word(8'(i));
    in_valid = 1'b0;
    check("s2_we2", ram2_write_en, 32'd1);
    check("s2_addr31", ram2_write_address, 32'd31);
    check("s2_stall", in_ready, 32'd0);
    check("s2_fb", full_bank, 32'd0);
    pulse_release();
    check("s2_fb_next", full_bank, 32'd1);
    check("s2_ready", in_ready, 32'd1);
    send_word(8'd64);
    in_valid = 1'b0;
    check("s2_w64_we", ram1_write_en, 32'd1);
    check("s2_w64_addr", ram1_write_address, 32'd0);

    // Scenario 3: last word of bank 0 coincides with release of bank 1
    for (int i = 65; i < 95; i++) send_word(8'(i));
    in_data = 8'd95;
    full_release = 1'b1;
    tick();
    full_release = 1'b0;
    check("s3_acc", 32'(m_acc), 32'd1);
    check("s3_ready", in_ready, 32'd1);
    check("s3_fb", full_bank, 32'd0);
    send_word(8'd96);
    in_valid = 1'b0;
    check("s3_we2", ram2_write_en, 32'd1);
    check("s3_addr0", ram2_write_address, 32'd0);
    pulse_release();
    for (int i = 97; i < 128; i++) send_word(8'(i));
    in_valid = 1'b0;
    check("s3_fb1", full_bank, 32'd1);
    pulse_release();

    // Scenario 4: in_valid every other cycle
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + i);
      tick();
      in_valid = 1'b0;
      tick();
    end
    check("s4_fv", full_valid, 32'd1);
    check("s4_fb", full_bank, 32'd0);
    pulse_release();

    // Scenario 5: stray release while nothing is offered, then random traffic
    pulse_release();
    check("s5_fv", full_valid, 32'd0);
    for (int c = 0; c < 1500; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = 8'($urandom);
      full_release = ($urandom_range(0, 7) == 0);
      tick();
    end
    in_valid = 1'b0;
    full_release = 1'b0;

    // Scenario 6: reset with bank 1 full and bank 0 at wr_ptr=17
    do_reset();
    for (int i = 0; i < 64; i++) send_word(8'(i));
    in_valid = 1'b0;
    pulse_release();
    for (int i = 0; i < 17; i++) send_word(8'(i + 8'h40));
    in_valid = 1'b0;
    tick();
    check("s6_fv", full_valid, 32'd1);
    check("s6_fb", full_bank, 32'd1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("s6_rst_fv", full_valid, 32'd0);
    check("s6_rst_fb", full_bank, 32'd0);
    check("s6_rst_ready", in_ready, 32'd1);
    check("s6_rst_we1", ram1_write_en, 32'd0);
    tick();
    resetn = 1'b1;
    send_word(8'hA5);
    in_valid = 1'b0;
    check("s6_we1", ram1_write_en, 32'd1);
    check("s6_addr", ram1_write_address, 32'd0);
    check("s6_data", ram1_write_data, 32'hA5);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
